// File: rtl/heap_sort_seq_if.sv
// Handshake bundle between the sort sequencer, its upstream/downstream byte
// streams and the heap it drives.
interface heap_sort_seq_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;
  logic              hp_push;
  logic              hp_pop;
  logic [DATA_W-1:0] hp_din;
  logic [DATA_W-1:0] hp_dout;
  logic [7:0]        hp_size;
  logic              hp_done;
  logic              hp_valid;

  modport master (
    input  in_data, in_valid, in_last, out_ready, hp_dout, hp_size, hp_done, hp_valid,
    output in_ready, out_data, out_valid, out_last, hp_push, hp_pop, hp_din
  );

  modport slave (
    output in_data, in_valid, in_last, out_ready, hp_dout, hp_size, hp_done, hp_valid,
    input  in_ready, out_data, out_valid, out_last, hp_push, hp_pop, hp_din
  );
endinterface

// File: rtl/heap_sort_seq.sv
// Batch sort sequencer: loads a byte batch into a heap, then drains it out in
// top-first order; a watchdog halts the block if the heap stops answering.
module heap_sort_seq #(
  parameter int MAX_COUNT = 255,
  parameter int TIMEOUT   = 255
) (
  input  logic            clk,
  input  logic            reset,
  heap_sort_seq_if.master bus,
  output logic [7:0]      count,
  output logic            trunc,
  output logic            err
);
  localparam int DATA_W = 8;
  localparam int WD_W   = 16;
  localparam logic [7:0]      MAX_C  = 8'(MAX_COUNT);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {LOAD, PUSH_WAIT, DRAIN, POP_WAIT, HALT} state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] hp_din_q, hp_din_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              hp_push_q, hp_push_d;
  logic              hp_pop_q, hp_pop_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              last_seen_q, last_seen_d;
  logic              trunc_q, trunc_d;
  logic              err_q, err_d;
  logic [7:0]        count_q, count_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [7:0]        count_inc;
  logic              in_hs, out_hs, at_max, wd_expired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LOAD;
      in_ready_q  <= 1'b0;
      hp_din_q    <= '0;
      out_data_q  <= '0;
      hp_push_q   <= 1'b0;
      hp_pop_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      last_seen_q <= 1'b0;
      trunc_q     <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      hp_din_q    <= hp_din_d;
      out_data_q  <= out_data_d;
      hp_push_q   <= hp_push_d;
      hp_pop_q    <= hp_pop_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      last_seen_q <= last_seen_d;
      trunc_q     <= trunc_d;
      err_q       <= err_d;
      count_q     <= count_d;
      wd_q        <= wd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hp_din_d    = hp_din_q;
    out_data_d  = out_data_q;
    hp_push_d   = 1'b0;
    hp_pop_d    = 1'b0;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    last_seen_d = last_seen_q;
    trunc_d     = trunc_q;
    err_d       = err_q;
    count_d     = count_q;
    count_inc   = count_q + 8'd1;
    at_max      = (count_inc == MAX_C);
    in_hs       = bus.in_valid & in_ready_q;
    out_hs      = out_valid_q & bus.out_ready;
    wd_expired  = (wd_q == WD_LIM);

    if (out_hs) out_valid_d = 1'b0;

    case (state_q)
      LOAD: begin
        if (in_hs) begin
          hp_din_d    = bus.in_data;
          hp_push_d   = 1'b1;
          count_d     = count_inc;
          last_seen_d = bus.in_last | at_max;
          if (at_max && !bus.in_last) trunc_d = 1'b1;
          state_d     = PUSH_WAIT;
        end
      end
      PUSH_WAIT: begin
        if (bus.hp_done) begin
          state_d = last_seen_q ? DRAIN : LOAD;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = HALT;
        end
      end
      DRAIN: begin
        if (bus.hp_size == 8'd0) begin
          count_d = '0;
          state_d = LOAD;
        end else if (bus.hp_valid && (!out_valid_q || out_hs)) begin
          // Capture the top now; the pop overlaps the downstream hold.
          out_data_d  = bus.hp_dout;
          out_valid_d = 1'b1;
          out_last_d  = (bus.hp_size == 8'd1);
          hp_pop_d    = 1'b1;
          state_d     = POP_WAIT;
        end
      end
      POP_WAIT: begin
        if (bus.hp_done) begin
          state_d = DRAIN;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = HALT;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = LOAD;
      end
    endcase

    if (state_d == HALT) out_valid_d = 1'b0;
    in_ready_d = (state_d == LOAD);

    if (hp_push_d || hp_pop_d) begin
      wd_d = '0;
    end else if (state_q == PUSH_WAIT || state_q == POP_WAIT) begin
      wd_d = wd_q + 16'd1;
    end else begin
      wd_d = wd_q;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.hp_push   = hp_push_q;
  assign bus.hp_pop    = hp_pop_q;
  assign bus.hp_din    = hp_din_q;
  assign count         = count_q;
  assign trunc         = trunc_q;
  assign err           = err_q;
endmodule

// File: tb/tb_heap_sort_seq.sv
// Scoreboard bench for heap_sort_seq: two instances (default batch limit and
// MAX_COUNT=4), each paired with a behavioural min-heap.
module tb_heap_sort_seq;
  localparam int TO       = 16;
  localparam int HEAP_LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] in_d;
  logic       in_v, in_l, out_rdy, pat_en, sel;
  int         drop_n;

  heap_sort_seq_if hif [2] ();

  logic [1:0][7:0] o_data, o_count, o_size, o_din;
  logic [1:0]      o_valid, o_last, o_iready, o_push, o_pop, o_trunc, o_err;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int MC = (g == 0) ? 255 : 4;
    logic [7:0] cnt_w;
    logic       trunc_w, err_w;
    logic [7:0] hq [$];
    logic       busy, op_push, drop;
    int         wait_n, npush;
    logic [7:0] val;

    assign hif[g].in_data   = in_d;
    assign hif[g].in_valid  = in_v && (int'(sel) == g);
    assign hif[g].in_last   = in_l;
    assign hif[g].out_ready = out_rdy;

    heap_sort_seq #(.MAX_COUNT(MC), .TIMEOUT(TO)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (hif[g]),
      .count (cnt_w),
      .trunc (trunc_w),
      .err   (err_w)
    );

    assign o_data[g]   = hif[g].out_data;
    assign o_valid[g]  = hif[g].out_valid;
    assign o_last[g]   = hif[g].out_last;
    assign o_iready[g] = hif[g].in_ready;
    assign o_push[g]   = hif[g].hp_push;
    assign o_pop[g]    = hif[g].hp_pop;
    assign o_din[g]    = hif[g].hp_din;
    assign o_size[g]   = hif[g].hp_size;
    assign o_count[g]  = cnt_w;
    assign o_trunc[g]  = trunc_w;
    assign o_err[g]    = err_w;

    // Min-heap partner: op accepted at the edge after the request, done HEAP_LAT edges later.
    assign hif[g].hp_valid = !busy && (hif[g].hp_size != 8'd0);
    always @(posedge clk or posedge reset) begin
      if (reset) begin
        hq.delete();
        busy           <= 1'b0;
        op_push        <= 1'b0;
        drop           <= 1'b0;
        wait_n         <= 0;
        npush          <= 0;
        val            <= 8'h00;
        hif[g].hp_done <= 1'b0;
        hif[g].hp_dout <= 8'h00;
        hif[g].hp_size <= 8'h00;
      end else begin
        hif[g].hp_done <= 1'b0;
        if (hif[g].hp_push) begin
          busy    <= 1'b1;
          op_push <= 1'b1;
          val     <= hif[g].hp_din;
          wait_n  <= HEAP_LAT;
          npush   <= npush + 1;
          drop    <= (g == 0) && (npush + 1 == drop_n);
        end else if (hif[g].hp_pop) begin
          busy    <= 1'b1;
          op_push <= 1'b0;
          wait_n  <= HEAP_LAT;
          drop    <= 1'b0;
        end else if (busy && !drop) begin
          if (wait_n > 1) begin
            wait_n <= wait_n - 1;
          end else begin
            if (op_push) begin
              hq.push_back(val);
              hq.sort();
            end else if (hq.size() != 0) begin
              void'(hq.pop_front());
            end
            busy           <= 1'b0;
            hif[g].hp_done <= 1'b1;
          end
        end
        hif[g].hp_size <= 8'(hq.size());
        hif[g].hp_dout <= (hq.size() != 0) ? hq[0] : 8'h00;
      end
    end
  end

  logic [7:0]  m_data, m_count, m_size, m_din;
  logic        m_valid, m_last, m_iready, m_push, m_pop, m_trunc, m_err;
  logic [30:0] all_outs;
  always_comb begin
    m_data   = o_data[sel];
    m_count  = o_count[sel];
    m_size   = o_size[sel];
    m_din    = o_din[sel];
    m_valid  = o_valid[sel];
    m_last   = o_last[sel];
    m_iready = o_iready[sel];
    m_push   = o_push[sel];
    m_pop    = o_pop[sel];
    m_trunc  = o_trunc[sel];
    m_err    = o_err[sel];
    all_outs = {m_iready, m_valid, m_last, m_push, m_pop, m_trunc, m_err, m_data, m_din, m_count};
  end

  logic [8:0] exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;
  int push_cyc = 0;
  int n_push_obs = 0;
  int n_pop_obs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Downstream ready: tied high, or the 1,0,0,1 stall pattern.
  initial begin
    int pidx;
    logic [3:0] pat;
    pidx = 0;
    pat = 4'b1001;
    out_rdy = 1'b1;
    forever begin
      tick();
      if (pat_en) begin
        out_rdy = pat[pidx[1:0]];
        pidx = (pidx + 1) % 4;
      end else begin
        out_rdy = 1'b1;
        pidx = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on each output handshake; checks push timing and stall hold.
  initial begin
    logic       prev_hs, prev_stall;
    logic [8:0] prev_out, e;
    prev_hs = 1'b0;
    prev_stall = 1'b0;
    prev_out = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_hs = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (m_push) begin
          n_push_obs++;
          push_cyc = cyc;
        end
        if (m_pop) n_pop_obs++;
        if (prev_hs || m_push) check("push_latency", 32'(m_push), 32'(prev_hs));
        if (m_push || m_pop) check("push_pop_excl", 32'(m_push & m_pop), 32'd0);
        if (prev_stall) check("stall_stable", {m_valid, m_last, m_data}, {1'b1, prev_out});
        if (m_valid && out_rdy) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL out_unexpected: got 0x%0h, expected no output", {m_last, m_data});
          end else begin
            e = exp_q.pop_front();
            check("out_last_data", {m_last, m_data}, e);
          end
        end
        prev_hs = in_v && m_iready;
        prev_stall = m_valid && !out_rdy;
        prev_out = {m_last, m_data};
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_d = d;
    in_l = l;
    in_v = 1'b1;
    while (!m_iready && n < 300) begin
      tick();
      n++;
    end
    if (!m_iready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready 0, expected 1");
    end
    tick();
    in_v = 1'b0;
    in_l = 1'b0;
  endtask

  task automatic expect_out(input logic [7:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && m_iready && !m_valid) && n < 600) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_in_ready"}, 32'(m_iready), 32'd1);
    check({name, "_count"}, 32'(m_count), 32'd0);
  endtask

  initial begin
    int np, nq, n;
    logic acc;
    in_d = 8'h00; in_v = 1'b0; in_l = 1'b0;
    pat_en = 1'b0; sel = 1'b0; drop_n = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'(all_outs), 32'd0);
    reset = 1'b0;
    tick();
    check("in_ready_after_reset", 32'(m_iready), 32'd1);

    // Five-byte batch, out_ready tied high
    expect_out(8'd1, 0); expect_out(8'd3, 0); expect_out(8'd5, 0);
    expect_out(8'd7, 0); expect_out(8'd9, 1);
    send(8'd5, 0); send(8'd3, 0); send(8'd9, 0); send(8'd1, 0); send(8'd7, 1);
    wait_drain("t1");
    check("t1_trunc", 32'(m_trunc), 32'd0);

    // Single byte batch
    np = n_push_obs; nq = n_pop_obs;
    expect_out(8'h42, 1);
    send(8'h42, 1);
    wait_drain("t2");
    check("t2_pushes", 32'(n_push_obs - np), 32'd1);
    check("t2_pops", 32'(n_pop_obs - nq), 32'd1);
    check("t2_heap_size", 32'(m_size), 32'd0);

    // Same batch with downstream stalls
    pat_en = 1'b1;
    expect_out(8'd1, 0); expect_out(8'd3, 0); expect_out(8'd5, 0);
    expect_out(8'd7, 0); expect_out(8'd9, 1);
    send(8'd5, 0); send(8'd3, 0); send(8'd9, 0); send(8'd1, 0); send(8'd7, 1);
    wait_drain("t4");
    pat_en = 1'b0;
    tick();

    // Truncation at MAX_COUNT=4
    sel = 1'b1;
    tick();
    expect_out(8'd2, 0); expect_out(8'd4, 0); expect_out(8'd6, 0); expect_out(8'd8, 1);
    send(8'd8, 0); send(8'd6, 0); send(8'd4, 0); send(8'd2, 0); send(8'd0, 0);
    check("t3_outputs_done", 32'(exp_q.size()), 32'd0);
    check("t3_trunc", 32'(m_trunc), 32'd1);
    check("t3_next_batch_count", 32'(m_count), 32'd1);
    repeat (3) tick();
    sel = 1'b0;
    tick();

    // Reset during POP_WAIT
    expect_out(8'd1, 0); expect_out(8'd3, 0); expect_out(8'd5, 0);
    expect_out(8'd7, 0); expect_out(8'd9, 1);
    send(8'd5, 0); send(8'd3, 0); send(8'd9, 0); send(8'd1, 0); send(8'd7, 1);
    n = 0;
    while (!m_pop && n < 200) begin
      tick();
      n++;
    end
    check("t6_reached_pop", 32'(m_pop), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_reset_outputs", 32'(all_outs), 32'd0);
    check("t6_heap_cleared", 32'(m_size), 32'd0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
    expect_out(8'd1, 0); expect_out(8'd2, 1);
    send(8'd2, 0); send(8'd1, 1);
    wait_drain("t6");

    // Watchdog: heap never answers the third push
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drop_n = 3;
    tick();
    send(8'd5, 0); send(8'd3, 0); send(8'd9, 0);
    n = 0;
    while (!m_err && n < 100) begin
      tick();
      n++;
    end
    check("t5_err_set", 32'(m_err), 32'd1);
    check("t5_err_latency", 32'(cyc - push_cyc), 32'(TO));
    in_d = 8'h55; in_v = 1'b1;
    acc = 1'b0;
    repeat (20) begin
      tick();
      acc = acc | m_iready | m_valid | m_push | m_pop;
    end
    check("t5_halt_quiet", 32'(acc), 32'd0);
    check("t5_err_sticky", 32'(m_err), 32'd1);
    in_v = 1'b0;
    drop_n = 0;
    reset = 1'b1;
    #1;
    check("t5_err_cleared", 32'(m_err), 32'd0);
    tick();
    reset = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench still running, expected completion");
    $fatal(1, "bench timeout");
  end
endmodule

// File: doc/heap_sort_seq.md
# heap_sort_seq

Batch sort sequencer that sits directly upstream of the `heap` block and drives its push/pop/done/valid interface. It accepts a byte stream through a valid/ready handshake and pushes each byte into the heap. When the last byte of a batch has been pushed, it drains the heap by popping every element and streams the bytes out through a valid/ready handshake, in top-first order. A watchdog flags a heap that never answers.

## Interface
- `MAX_COUNT`, default 255: maximum bytes per batch, 1..255; never exceeds heap capacity.
- `TIMEOUT`, default 255: cycles allowed between issuing `hp_push`/`hp_pop` and seeing `hp_done`.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high; shared with the heap instance.
- `in_data` input 8: upstream byte.
- `in_valid` input 1: upstream byte present.
- `in_last` input 1: marks the final byte of a batch; sampled with `in_data`.
- `in_ready` output 1: sequencer accepts a byte this cycle.
- `out_data` output 8: sorted byte.
- `out_valid` output 1: `out_data` present.
- `out_last` output 1: marks the final byte of the drained batch.
- `out_ready` input 1: downstream accepts.
- `hp_push` output 1: one-cycle push request to the heap.
- `hp_pop` output 1: one-cycle pop request to the heap.
- `hp_din` output 8: byte to push; held stable until `hp_done`.
- `hp_dout` input 8: heap top value.
- `hp_size` input 8: heap element count.
- `hp_done` input 1: heap operation complete, one-cycle pulse.
- `hp_valid` input 1: heap idle and non-empty.
- `count` output 8: bytes pushed in the current batch.
- `trunc` output 1: sticky; the batch was cut at `MAX_COUNT` without `in_last`.
- `err` output 1: sticky; watchdog expired.

## Operation
- States: LOAD (reset state), PUSH_WAIT, DRAIN, POP_WAIT, HALT.
- All outputs are registered. Reset value of every output is 0, including `in_ready`. The state resets to LOAD and `count` resets to 0.
- LOAD:
  - `in_ready` is 1.
  - A handshake (`in_valid & in_ready`) latches `in_data` into `hp_din`, pulses `hp_push` the next cycle, increments `count`, latches `last_seen = in_last | (count+1 == MAX_COUNT)`, and moves to PUSH_WAIT.
  - `trunc` is set if `count+1 == MAX_COUNT` and `in_last` is 0.
- PUSH_WAIT:
  - `in_ready` is 0 and the watchdog runs.
  - On `hp_done`: go to DRAIN if `last_seen`, else return to LOAD.
- DRAIN:
  - If `hp_size == 0`: clear `count`, `trunc` stays, go to LOAD.
  - Else, when `hp_valid` and `out_valid` are 0, or a handshake is completing this cycle:
    - `out_data <= hp_dout`, `out_valid <= 1`, `out_last <= (hp_size == 1)`.
    - Pulse `hp_pop` the next cycle and go to POP_WAIT.
- POP_WAIT:
  - The watchdog runs.
  - On `hp_done`, go to DRAIN.
  - The output handshake may complete during POP_WAIT. The pop is overlapped with the output hold.
- Output register: `out_valid` holds, with `out_data`/`out_last` stable, until `out_ready`. It clears on the handshake unless reloaded in the same cycle.
- Watchdog: an 8-bit-or-wider counter, cleared on each `hp_push`/`hp_pop`. If it reaches `TIMEOUT` before `hp_done`, set `err` and enter HALT.
- HALT: all handshakes are deasserted and `hp_push`/`hp_pop` are held at 0. Only `reset` exits HALT.
- `hp_done` outside PUSH_WAIT/POP_WAIT is ignored.
- An `in_valid` while `in_ready` is 0 is not consumed; upstream must hold the byte.

## Timing
- Push issue latency: handshake at cycle N, then `hp_push` high at N+1 only.
- Next `in_ready`: the cycle after `hp_done` is seen, unless the batch is ending.
- Drain: `hp_pop` is high exactly one cycle after the capture cycle. The next capture happens no earlier than the cycle after `hp_done`.
- Per-batch throughput is bounded by heap latency. The sequencer adds 2 cycles per element beyond the heap's push/pop time.
- `hp_push` and `hp_pop` are never high in the same cycle. Neither is re-issued before `hp_done`.
- Reset mid-operation: everything returns to reset values immediately and asynchronously. The heap resets on the same net, so no partial batch survives. Any in-flight `out_data` is discarded.

## Test plan
- Behavioural min-heap model as DUT partner. Input 5,3,9,1,7 with `in_last` on 7 and `out_ready` tied 1 -> output 1,3,5,7,9; `out_last` only on 9; `count` = 0 and `in_ready` = 1 after the drain.
- Single byte 0x42 with `in_last` -> one push, one pop; output 0x42 with `out_last` = 1; `hp_size` returns to 0.
- `MAX_COUNT` = 4, five bytes 8,6,4,2,0 with no `in_last` -> 2,4,6,8 emitted with `out_last` on 8; `trunc` = 1; byte 0 is accepted into the next batch.
- `out_ready` toggling 1,0,0,1 across the first test -> no byte is lost or duplicated; `out_data` is stable while stalled.
- Heap model drops `hp_done` on the third push, `TIMEOUT` = 16 -> `err` = 1 at 16 cycles after that `hp_push`; `in_ready`, `out_valid`, `hp_push` and `hp_pop` stay 0 until reset.
- Assert `reset` during POP_WAIT of the first test -> all outputs 0 that cycle; after release, a new batch of 2,1 with `in_last` outputs 1,2.
